// File: rtl/spi_reg_pkg.sv
// Shared types and register map for the SPI register-bank controller.
// Address constants, the queued transaction record and the pop FSM states.
package spi_reg_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;
  localparam logic [6:0] MAX_ADDR       = 7'h04;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } txn_t;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Decoded transaction stream from the SPI deserializer.
// drain_hold is a debug stall that freezes popping so the FIFO can be filled.
interface spi_reg_ctrl_if;
  logic       txn_valid;
  logic       txn_rw;
  logic [6:0] txn_addr;
  logic [7:0] txn_data;
  logic       drain_hold;

  modport master (output txn_valid, txn_rw, txn_addr, txn_data, drain_hold);
  modport slave  (input  txn_valid, txn_rw, txn_addr, txn_data, drain_hold);
endinterface

// File: rtl/spi_reg_ctrl_txn_fifo.sv
// Small synchronous FIFO of transaction records with a combinational head read.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module txn_fifo
  import spi_reg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  txn_t                     wr_data,
  output txn_t                     rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  txn_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q,  count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; clearing the pointers is enough to flush it.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Register-bank controller: buffers SPI transactions, decodes writes, and
// commits double-buffered PWM settings only on a PWM period boundary.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [6:0] MAX_ADDR   = spi_reg_pkg::MAX_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_reg_ctrl_if.slave        bus,
  input  logic                 update_ok,
  output logic [7:0]           en_reg_out_7_0,
  output logic [7:0]           en_reg_out_15_8,
  output logic [7:0]           en_reg_pwm_7_0,
  output logic [7:0]           en_reg_pwm_15_8,
  output logic [7:0]           pwm_duty_cycle,
  output logic                 pending,
  output logic [7:0]           err_count,
  output logic [7:0]           drop_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state_q, state_d;
  txn_t          head, wr_txn;
  logic          fifo_full, fifo_empty, pop, push_ok;
  logic [CW-1:0] fifo_count;

  logic [7:0] out_lo_q, out_lo_d, out_hi_q, out_hi_d;
  logic [7:0] sh_lo_q, sh_lo_d, sh_hi_q, sh_hi_d, sh_duty_q, sh_duty_d;
  logic [7:0] act_lo_q, act_lo_d, act_hi_q, act_hi_d, act_duty_q, act_duty_d;
  logic [7:0] err_q, err_d, drop_q, drop_d;
  logic       dirty_q, dirty_d;

  assign wr_txn  = '{rw: bus.txn_rw, addr: bus.txn_addr, data: bus.txn_data};
  assign pop     = (state_q == ST_DRAIN) && !fifo_empty && !bus.drain_hold;
  assign push_ok = bus.txn_valid && (!fifo_full || pop);

  txn_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_ok),
    .pop     (pop),
    .wr_data (wr_txn),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (push_ok) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && fifo_count == CW'(1) && !push_ok) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_lo_d   = out_lo_q;
    out_hi_d   = out_hi_q;
    sh_lo_d    = sh_lo_q;
    sh_hi_d    = sh_hi_q;
    sh_duty_d  = sh_duty_q;
    act_lo_d   = act_lo_q;
    act_hi_d   = act_hi_q;
    act_duty_d = act_duty_q;
    dirty_d    = dirty_q;
    err_d      = err_q;
    drop_d     = drop_q;

    if (pop && head.rw) begin
      case (head.addr)
        ADDR_EN_OUT_LO: out_lo_d = head.data;
        ADDR_EN_OUT_HI: out_hi_d = head.data;
        ADDR_EN_PWM_LO: begin sh_lo_d   = head.data; dirty_d = 1'b1; end
        ADDR_EN_PWM_HI: begin sh_hi_d   = head.data; dirty_d = 1'b1; end
        ADDR_DUTY:      begin sh_duty_d = head.data; dirty_d = 1'b1; end
        default:        if (head.addr > MAX_ADDR) err_d = sat_inc(err_q);
      endcase
    end

    // Commit sees this cycle's shadow write, so a same-edge write is not lost.
    if (update_ok && dirty_d) begin
      act_lo_d   = sh_lo_d;
      act_hi_d   = sh_hi_d;
      act_duty_d = sh_duty_d;
      dirty_d    = 1'b0;
    end

    if (bus.txn_valid && !push_ok) drop_d = sat_inc(drop_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      out_lo_q   <= '0;
      out_hi_q   <= '0;
      sh_lo_q    <= '0;
      sh_hi_q    <= '0;
      sh_duty_q  <= '0;
      act_lo_q   <= '0;
      act_hi_q   <= '0;
      act_duty_q <= '0;
      dirty_q    <= 1'b0;
      err_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      out_lo_q   <= out_lo_d;
      out_hi_q   <= out_hi_d;
      sh_lo_q    <= sh_lo_d;
      sh_hi_q    <= sh_hi_d;
      sh_duty_q  <= sh_duty_d;
      act_lo_q   <= act_lo_d;
      act_hi_q   <= act_hi_d;
      act_duty_q <= act_duty_d;
      dirty_q    <= dirty_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = act_lo_q;
  assign en_reg_pwm_15_8 = act_hi_q;
  assign pwm_duty_cycle  = act_duty_q;
  assign pending         = dirty_q;
  assign err_count       = err_q;
  assign drop_count      = drop_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed vector table, hand-written
// corner sequences, then random traffic against a queue-based reference model.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       update_ok = 1'b0;
  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty, err_cnt, drop_cnt;
  logic       pending;

  always #5 clk = ~clk;

  spi_reg_ctrl_if bus();

  spi_reg_ctrl #(.FIFO_DEPTH(4), .MAX_ADDR(7'h04)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .update_ok       (update_ok),
    .en_reg_out_7_0  (out_lo),
    .en_reg_out_15_8 (out_hi),
    .en_reg_pwm_7_0  (pwm_lo),
    .en_reg_pwm_15_8 (pwm_hi),
    .pwm_duty_cycle  (duty),
    .pending         (pending),
    .err_count       (err_cnt),
    .drop_count      (drop_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a bounded queue plus the register file as plain variables.
  typedef struct { bit rw; bit [6:0] a; bit [7:0] d; } mtxn_t;
  mtxn_t    mq[$];
  bit [7:0] m_olo, m_ohi, m_sh[3], m_act[3], m_err, m_drop;
  bit       m_dirty;

  task automatic model_reset();
    mq.delete();
    m_olo = 0; m_ohi = 0; m_err = 0; m_drop = 0; m_dirty = 0;
    for (int i = 0; i < 3; i++) begin m_sh[i] = 0; m_act[i] = 0; end
  endtask

  task automatic model_edge(input bit v, input bit rw, input bit [6:0] a,
                            input bit [7:0] d, input bit uok, input bit hold);
    bit    do_pop, do_push;
    mtxn_t e;
    do_pop  = (mq.size() > 0) && !hold;
    do_push = v && ((mq.size() < 4) || do_pop);
    if (do_pop) begin
      e = mq.pop_front();
      if (e.rw) begin
        if (e.a == 0) m_olo = e.d;
        else if (e.a == 1) m_ohi = e.d;
        else if (e.a <= 4) begin m_sh[e.a - 2] = e.d; m_dirty = 1; end
        else if (m_err != 8'hFF) m_err = m_err + 1;
      end
    end
    if (uok && m_dirty) begin
      for (int i = 0; i < 3; i++) m_act[i] = m_sh[i];
      m_dirty = 0;
    end
    if (v && !do_push && m_drop != 8'hFF) m_drop = m_drop + 1;
    if (do_push) mq.push_back('{rw: rw, a: a, d: d});
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  task automatic step(input bit v, input bit rw, input bit [6:0] a, input bit [7:0] d,
                      input bit uok, input bit hold);
    @(negedge clk);
    bus.txn_valid = v; bus.txn_rw = rw; bus.txn_addr = a; bus.txn_data = d;
    update_ok = uok; bus.drain_hold = hold;
    @(posedge clk);
    model_edge(v, rw, a, d, uok, hold);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 7'h00, 8'h00, 0, 0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_out_lo"}, out_lo, m_olo);
    chk({tag, "_out_hi"}, out_hi, m_ohi);
    chk({tag, "_pwm_lo"}, pwm_lo, m_act[0]);
    chk({tag, "_pwm_hi"}, pwm_hi, m_act[1]);
    chk({tag, "_duty"},   duty,   m_act[2]);
    chk({tag, "_pend"},   {7'd0, pending}, {7'd0, m_dirty});
    chk({tag, "_err"},    err_cnt,  m_err);
    chk({tag, "_drop"},   drop_cnt, m_drop);
  endtask

  typedef struct {
    bit rw; bit [6:0] a; bit [7:0] d; bit uok;
    bit [7:0] olo, ohi, plo, phi, dut; bit pend; bit [7:0] err;
  } vec_t;
  vec_t vt[15];

  initial begin
    bus.txn_valid = 0; bus.txn_rw = 0; bus.txn_addr = 0; bus.txn_data = 0;
    bus.drain_hold = 0;
    model_reset();

    //         rw  addr   data   uok  olo    ohi    plo    phi    duty   pend err
    vt[0]  = '{1, 7'h01, 8'hA5, 0, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 8'd0};
    vt[1]  = '{1, 7'h04, 8'h80, 0, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 1, 8'd0};
    vt[2]  = '{0, 7'h00, 8'h00, 1, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h80, 0, 8'd0};
    vt[3]  = '{1, 7'h02, 8'h0F, 1, 8'h00, 8'hA5, 8'h0F, 8'h00, 8'h80, 0, 8'd0};
    vt[4]  = '{1, 7'h10, 8'h55, 0, 8'h00, 8'hA5, 8'h0F, 8'h00, 8'h80, 0, 8'd1};
    vt[5]  = '{1, 7'h7F, 8'h33, 0, 8'h00, 8'hA5, 8'h0F, 8'h00, 8'h80, 0, 8'd2};
    vt[6]  = '{0, 7'h00, 8'hFF, 0, 8'h00, 8'hA5, 8'h0F, 8'h00, 8'h80, 0, 8'd2};
    vt[7]  = '{1, 7'h00, 8'h3C, 0, 8'h3C, 8'hA5, 8'h0F, 8'h00, 8'h80, 0, 8'd2};
    vt[8]  = '{1, 7'h03, 8'hC3, 0, 8'h3C, 8'hA5, 8'h0F, 8'h00, 8'h80, 1, 8'd2};
    vt[9]  = '{0, 7'h03, 8'h00, 1, 8'h3C, 8'hA5, 8'h0F, 8'hC3, 8'h80, 0, 8'd2};
    vt[10] = '{1, 7'h05, 8'h11, 0, 8'h3C, 8'hA5, 8'h0F, 8'hC3, 8'h80, 0, 8'd3};
    vt[11] = '{1, 7'h04, 8'h01, 0, 8'h3C, 8'hA5, 8'h0F, 8'hC3, 8'h80, 1, 8'd3};
    vt[12] = '{0, 7'h7F, 8'h00, 0, 8'h3C, 8'hA5, 8'h0F, 8'hC3, 8'h80, 1, 8'd3};
    vt[13] = '{0, 7'h00, 8'h00, 1, 8'h3C, 8'hA5, 8'h0F, 8'hC3, 8'h01, 0, 8'd3};
    vt[14] = '{0, 7'h00, 8'h00, 1, 8'h3C, 8'hA5, 8'h0F, 8'hC3, 8'h01, 0, 8'd3};

    #12;
    check_model("reset");
    @(negedge clk);
    rst = 0;

    // Each row: transaction on one edge, its pop (with optional update_ok) on the next.
    for (int i = 0; i < 15; i++) begin
      step(1, vt[i].rw, vt[i].a, vt[i].d, 0, 0);
      if (i == 0) chk("latency_n_out_hi", out_hi, 8'h00);
      step(0, 0, 7'h00, 8'h00, vt[i].uok, 0);
      chk($sformatf("vec%0d_out_lo", i), out_lo, vt[i].olo);
      chk($sformatf("vec%0d_out_hi", i), out_hi, vt[i].ohi);
      chk($sformatf("vec%0d_pwm_lo", i), pwm_lo, vt[i].plo);
      chk($sformatf("vec%0d_pwm_hi", i), pwm_hi, vt[i].phi);
      chk($sformatf("vec%0d_duty", i),   duty,   vt[i].dut);
      chk($sformatf("vec%0d_pend", i),   {7'd0, pending}, {7'd0, vt[i].pend});
      chk($sformatf("vec%0d_err", i),    err_cnt, vt[i].err);
      $display("vec %0d rw=%0d addr=%02h data=%02h uok=%0d -> duty=%02h pend=%0d err=%0d",
               i, vt[i].rw, vt[i].a, vt[i].d, vt[i].uok, duty, pending, err_cnt);
    end

    // Fill the FIFO while draining is held, then every further pulse is dropped.
    for (int k = 0; k < 4; k++) step(1, 1, 7'h00, 8'h10 + 8'(k), 0, 1);
    for (int k = 1; k <= 6; k++) begin
      step(1, 1, 7'h00, 8'hEE, 0, 1);
      chk($sformatf("drop_inc%0d", k), drop_cnt, 8'(k));
      $display("drop pulse %0d drop_count=%0d", k, drop_cnt);
    end
    // Full FIFO with a pop in the same cycle still accepts the push.
    step(1, 1, 7'h00, 8'h99, 0, 0);
    chk("push_on_full_pop", drop_cnt, 8'd6);
    idle(6);
    chk("drain_last_out_lo", out_lo, 8'h99);
    check_model("after_drain");

    for (int k = 0; k < 4; k++) step(1, 1, 7'h01, 8'h20 + 8'(k), 0, 1);
    for (int k = 0; k < 300; k++) step(1, 1, 7'h00, 8'hEE, 0, 1);
    chk("drop_saturate", drop_cnt, 8'hFF);
    $display("after 306 drops drop_count=%02h", drop_cnt);
    idle(6);
    check_model("after_sat");

    // Asynchronous reset in the middle of a drain with three entries queued.
    for (int k = 0; k < 3; k++) step(1, 1, 7'h01, 8'h77 + 8'(k), 0, 1);
    @(negedge clk);
    bus.txn_valid = 0; bus.drain_hold = 0; update_ok = 0;
    @(posedge clk);
    model_edge(0, 0, 7'h00, 8'h00, 0, 0);
    #1;
    chk("pre_reset_out_hi", out_hi, 8'h77);
    #1;
    rst = 1;
    model_reset();
    #1;
    check_model("async_reset");
    $display("async reset mid-drain out_hi=%02h drop=%02h", out_hi, drop_cnt);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    idle(6);
    chk("no_replay_out_hi", out_hi, 8'h00);
    check_model("post_reset");

    // Random traffic compared against the model every cycle.
    for (int i = 0; i < 500; i++) begin
      bit       v, rw, uok, hold;
      bit [6:0] a;
      v    = ($urandom_range(0, 3) != 0);
      rw   = ($urandom_range(0, 3) != 0);
      a    = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'($urandom_range(0, 5));
      uok  = ($urandom_range(0, 5) == 0);
      hold = ($urandom_range(0, 4) == 0);
      step(v, rw, a, 8'($urandom), uok, hold);
      check_model($sformatf("rnd%0d", i));
      if (i % 50 == 0)
        $display("rnd %0d v=%0d rw=%0d addr=%02h uok=%0d hold=%0d q=%0d",
                 i, v, rw, a, uok, hold, mq.size());
    end
    idle(8);
    check_model("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Register-bank controller that sits directly behind the SPI deserializer, consuming its decoded transaction stream (read/write flag, 7-bit address, 8-bit data, one-cycle valid). Buffers transactions in a small FIFO, decodes addresses, and writes the output-enable and PWM configuration registers. PWM registers are double-buffered and committed only on a PWM period boundary, so the PWM generator never sees a torn configuration. Also keeps saturating error and overflow counters for debug readout.

## Interface
- FIFO_DEPTH, 4, transaction buffer depth; power of two, ≥2
- MAX_ADDR, 7'h04, highest implemented register address
- clk  in  1  system clock; sole clock
- rst  in  1  asynchronous, active-high reset
- txn_valid  in  1  one-cycle pulse: transaction fields valid
- txn_rw  in  1  1 = write, 0 = read
- txn_addr  in  7  register address
- txn_data  in  8  write data
- update_ok  in  1  one-cycle pulse at PWM period end; commit window
- en_reg_out_7_0  out  8  output enables, bits 7:0
- en_reg_out_15_8  out  8  output enables, bits 15:8
- en_reg_pwm_7_0  out  8  active PWM enables, bits 7:0
- en_reg_pwm_15_8  out  8  active PWM enables, bits 15:8
- pwm_duty_cycle  out  8  active duty cycle
- pending  out  1  uncommitted PWM shadow data exists
- err_count  out  8  saturating count of writes to addr > MAX_ADDR
- drop_count  out  8  saturating count of transactions lost to FIFO full

## Operation
- Push: txn_valid with FIFO not full → enqueue {rw, addr, data}. Push is also accepted when full if a pop occurs the same cycle. Otherwise drop; drop_count +1, saturating at 8'hFF.
- Pop FSM, two states:
  - IDLE: FIFO empty; go to DRAIN when the FIFO becomes non-empty.
  - DRAIN: pop one entry per cycle; return to IDLE when the last entry is popped and no push arrives that cycle.
- Popped entry decode:
  - Write, addr 0x00/0x01: update en_reg_out_7_0 / en_reg_out_15_8 directly.
  - Write, addr 0x02..0x04: update the matching shadow register (pwm_7_0, pwm_15_8, duty) and set dirty.
  - Write, addr > MAX_ADDR: discarded; err_count +1, saturating.
  - Read (rw = 0), any addr: discarded, no side effects, no counter change.
- Commit: on update_ok with dirty = 1, copy all three shadows to the active PWM outputs and clear dirty.
  - Shadow write and update_ok in the same cycle: the commit carries the newly written value; dirty ends at 0.
  - update_ok with dirty = 0: no effect.
- pending = dirty.
- Reset, including mid-drain: FIFO flushed, pointers cleared, FSM to IDLE, dirty cleared, all outputs and shadows 0, both counters 0.

## Timing
- All outputs registered; reset value 0 for every output.
- Latency, txn_valid at edge N into an empty FIFO:
  - pop at edge N+1;
  - direct register or shadow visible after edge N+1.
- PWM active outputs change only on the edge that samples update_ok = 1.
- Back-to-back txn_valid on consecutive cycles sustained indefinitely with no drops; throughput 1 txn/cycle.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter width $clog2(FIFO_DEPTH)+1.
- Counters saturate; no wrap to 0.

## Structure
- Shared package spi_reg_pkg:
  - address constants ADDR_EN_OUT_LO/HI, ADDR_EN_PWM_LO/HI, ADDR_DUTY;
  - MAX_ADDR;
  - transaction struct {rw, addr[6:0], data[7:0]};
  - FSM state enum.
- One sub-module txn_fifo: parameterized synchronous FIFO with push, pop, full, empty, and simultaneous push/pop when full.
- Decode, shadows, commit logic and counters live in the top module.

## Test plan
- Reset, then write 0x01←0xA5 → en_reg_out_15_8 = 0xA5 two edges after txn_valid; all other outputs 0.
- Write 0x04←0x80, no update_ok → pwm_duty_cycle stays 0, pending = 1. Pulse update_ok → pwm_duty_cycle = 0x80, pending = 0.
- Write 0x02←0x0F with update_ok on that entry's pop edge → en_reg_pwm_7_0 = 0x0F on that edge, pending = 0.
- Write to addr 0x10 and 0x7F → err_count = 2, no register changes. Read of addr 0x00 → nothing changes.
- Six txn_valid pulses with the FSM held off by a preloaded full FIFO (DEPTH = 4) → drop_count increments per rejected pulse. Drive 300 drops → drop_count = 0xFF.
- Assert rst mid-DRAIN with 3 entries queued → all outputs 0 asynchronously; the queued entries are never applied after release.
